// File: rtl/mac_pkg.sv
// Shared types and constants for the 4-bit multiply-accumulate sequencer.
package mac_pkg;

    localparam int OP_W    = 4;
    localparam int PROD_W  = 8;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } mac_state_e;

endpackage

// File: rtl/mac_mult_4x4.sv
// Combinational 4x4 unsigned multiplier: carry-save (Wallace) reduction of the
// four partial-product rows, then a single carry-propagate add.
module mac_mult_4x4
    import mac_pkg::*;
(
    input  logic [OP_W-1:0]   i_a,
    input  logic [OP_W-1:0]   i_b,
    output logic [PROD_W-1:0] o_p
);

    logic [PROD_W-1:0] w_pp [OP_W];
    logic [PROD_W-1:0] w_s1, w_c1, w_s2, w_c2;

    for (genvar i = 0; i < OP_W; i++) begin : g_pp
        assign w_pp[i] = {{(PROD_W-OP_W){1'b0}}, i_a & {OP_W{i_b[i]}}} << i;
    end

    // Two 3:2 compressor layers; carries dropped off the top cannot occur since p < 256.
    assign w_s1 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
    assign w_c1 = ((w_pp[0] & w_pp[1]) | (w_pp[0] & w_pp[2]) | (w_pp[1] & w_pp[2])) << 1;
    assign w_s2 = w_s1 ^ w_c1 ^ w_pp[3];
    assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_pp[3]) | (w_c1 & w_pp[3])) << 1;

    assign o_p = w_s2 + w_c2;

endmodule

// File: rtl/mac_4b_sequencer.sv
// Job sequencer: accepts len_m1+1 operand pairs, accumulates their products
// through a one-stage product register and presents the sum with a handshake.
//
//  state   | meaning
//  S_IDLE  | waiting for start
//  S_RUN   | accepting operand pairs while remaining count > 0
//  S_DRAIN | last product accumulating
//  S_DONE  | result valid, waiting for res_ready
module mac_4b_sequencer
    import mac_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       len_m1,
    input  logic             abort,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [OP_W-1:0]  op_a,
    input  logic [OP_W-1:0]  op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    mac_state_e        r_state;
    logic [CNT_W-1:0]  r_remain;
    logic [PROD_W-1:0] r_prod;
    logic              r_pvld;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;
    logic              r_op_ready;
    logic              r_res_valid;
    logic              r_busy;

    logic [PROD_W-1:0] w_prod;
    logic              w_xfer;
    logic [ACC_W:0]    w_sum;

    mac_mult_4x4 u_mult (
        .i_a (op_a),
        .i_b (op_b),
        .o_p (w_prod)
    );

    assign w_xfer = r_op_ready & op_valid;
    assign w_sum  = {1'b0, r_acc} + {{(ACC_W+1-PROD_W){1'b0}}, r_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remain    <= '0;
            r_prod      <= '0;
            r_pvld      <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (abort && r_state != S_IDLE) begin
            // Pending product is dropped; accumulator keeps its last value.
            r_state     <= S_IDLE;
            r_pvld      <= 1'b0;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (r_pvld) begin
                r_acc <= w_sum[ACC_W-1:0];
                if (w_sum[ACC_W]) r_ovf <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_remain   <= CNT_W'(len_m1) + CNT_W'(1);
                        r_acc      <= '0;
                        r_pvld     <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_op_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_pvld <= w_xfer;
                    if (w_xfer) begin
                        r_prod   <= w_prod;
                        r_remain <= r_remain - CNT_W'(1);
                        if (r_remain == CNT_W'(1)) begin
                            r_op_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_pvld      <= 1'b0;
                    r_res_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign op_ready  = r_op_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_acc;
    assign res_ovf   = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mac_4b_sequencer.sv
// Bench for mac_4b_sequencer: directed and randomized jobs on a 12-bit and an
// 8-bit accumulator instance, checked against a plain sum-of-products model.
module tb_mac_4b_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, start8, abort, op_valid, res_ready;
    logic [3:0]  len_m1, op_a, op_b;
    logic        op_ready, res_valid, res_ovf, busy;
    logic [11:0] res_data;
    logic        op_ready8, res_valid8, res_ovf8, busy8;
    logic [7:0]  res_data8;
    logic        sel;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mac_4b_sequencer #(.ACC_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .len_m1(len_m1), .abort(abort),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .busy(busy)
    );

    mac_4b_sequencer #(.ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .len_m1(len_m1), .abort(abort),
        .op_valid(op_valid), .op_ready(op_ready8), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid8), .res_ready(res_ready), .res_data(res_data8),
        .res_ovf(res_ovf8), .busy(busy8)
    );

    logic        m_op_ready, m_res_valid, m_res_ovf, m_busy;
    logic [11:0] m_res_data;
    assign m_op_ready  = sel ? op_ready8  : op_ready;
    assign m_res_valid = sel ? res_valid8 : res_valid;
    assign m_res_ovf   = sel ? res_ovf8   : res_ovf;
    assign m_busy      = sel ? busy8      : busy;
    assign m_res_data  = sel ? {4'b0, res_data8} : res_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_start(input bit s, input logic v);
        if (s) start8 = v;
        else   start  = v;
    endtask

    // One full job: n pairs, gap_pct percent idle offers, optional fixed operands,
    // hold cycles of res_ready low (with start pulses that must be ignored).
    task automatic do_job(input bit s, input int n, input int gap_pct, input bit fixed,
                          input logic [3:0] fa, input logic [3:0] fb, input int hold);
        int         total, xfers, budget, accw, exp_data;
        bit         x;
        logic [3:0] a, b;
        sel = s; accw = s ? 8 : 12; total = 0; xfers = 0; budget = 400;
        len_m1 = 4'(n - 1);
        set_start(s, 1'b1);
        tick();
        set_start(s, 1'b0);
        chk("busy_after_start", m_busy, 1);
        while (xfers < n && budget > 0) begin
            chk("op_ready_run", m_op_ready, 1);
            a = fixed ? fa : 4'($urandom);
            b = fixed ? fb : 4'($urandom);
            op_a = a; op_b = b;
            op_valid = ($urandom_range(0, 99) >= gap_pct);
            x = op_valid;
            tick();
            budget--;
            if (x) begin
                total += int'(a) * int'(b);
                xfers++;
            end
        end
        chk("transfer_count", xfers, n);
        // Further offers in DRAIN/DONE must be refused.
        op_valid = 1'b1; op_a = 4'd15; op_b = 4'd15;
        chk("drain_op_ready", m_op_ready, 0);
        chk("drain_res_valid", m_res_valid, 0);
        chk("drain_busy", m_busy, 1);
        tick();
        exp_data = total % (1 << accw);
        chk("done_res_valid", m_res_valid, 1);
        chk("done_res_data", m_res_data, exp_data);
        chk("done_res_ovf", m_res_ovf, total >= (1 << accw));
        op_valid = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            set_start(s, i[0]);
            tick();
            chk("hold_res_valid", m_res_valid, 1);
            chk("hold_res_data", m_res_data, exp_data);
        end
        res_ready = 1'b1;
        set_start(s, 1'b1);
        tick();
        res_ready = 1'b0;
        set_start(s, 1'b0);
        chk("idle_res_valid", m_res_valid, 0);
        chk("idle_busy", m_busy, 0);
        chk("idle_op_ready", m_op_ready, 0);
        tick();
        chk("start_at_handshake_ignored", m_busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start8 = 1'b0; abort = 1'b0; op_valid = 1'b0;
        res_ready = 1'b0; len_m1 = 4'd0; op_a = 4'd0; op_b = 4'd0; sel = 1'b0;
        tick();
        tick();
        chk("rst_op_ready", op_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_ovf", res_ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst8_busy", busy8, 0);
        chk("rst8_res_data", res_data8, 0);
        rst = 1'b0;
        tick();

        do_job(0, 1, 0, 1, 4'd15, 4'd15, 0);
        do_job(0, 16, 40, 1, 4'd15, 4'd15, 0);
        do_job(1, 2, 0, 1, 4'd15, 4'd15, 0);
        do_job(0, 1, 0, 1, 4'd15, 4'd15, 10);

        for (int j = 0; j < 6; j++) do_job(0, $urandom_range(1, 16), 30, 0, 4'd0, 4'd0, 0);
        for (int j = 0; j < 4; j++) do_job(1, $urandom_range(1, 16), 30, 0, 4'd0, 4'd0, 0);

        // Abort after three transfers of an eight-pair job.
        sel = 1'b0;
        len_m1 = 4'd7; start = 1'b1;
        tick();
        start = 1'b0; op_valid = 1'b1; op_a = 4'($urandom); op_b = 4'($urandom);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; op_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_op_ready", op_ready, 0);
        chk("abort_res_valid", res_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_abort_res_valid", res_valid, 0);
        end
        do_job(0, 1, 0, 1, 4'd3, 4'd5, 0);

        // Abort while the result is waiting in DONE.
        len_m1 = 4'd0; start = 1'b1;
        tick();
        start = 1'b0; op_valid = 1'b1; op_a = 4'd2; op_b = 4'd2;
        tick();
        op_valid = 1'b0;
        tick();
        chk("pre_abort_done_valid", res_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done_res_valid", res_valid, 0);
        chk("abort_done_busy", busy, 0);

        // Reset while draining.
        len_m1 = 4'd0; start = 1'b1;
        tick();
        start = 1'b0; op_valid = 1'b1; op_a = 4'd9; op_b = 4'd7;
        tick();
        op_valid = 1'b0;
        chk("pre_rst_drain_busy", busy, 1);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        chk("rst_drain_op_ready", op_ready, 0);
        chk("rst_drain_res_valid", res_valid, 0);
        chk("rst_drain_res_ovf", res_ovf, 0);
        chk("rst_drain_busy", busy, 0);
        chk("rst_drain_res_data", res_data, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_res_valid", res_valid, 0);
            chk("post_rst_busy", busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
